// File: rtl/day6_stream_n.sv
// day6_stream_n: column-stream worksheet evaluator.
// Rows fold per column; each block combines row-wise and column-wise.
module day6_stream_n #(
    parameter int ROWS  = 4,
    parameter int ACC_W = 64,
    parameter int CNT_W = 16
) (
    input  logic              clock,
    input  logic              clear_n,
    input  logic              load,
    input  logic              col_valid,
    output logic              ready,
    input  logic [4*ROWS-1:0] digit,
    input  logic [ROWS-1:0]   space,
    input  logic              block_start,
    input  logic              block_plus,
    input  logic              col_last,
    input  logic              frame_last,
    output logic [ACC_W-1:0]  part1_result,
    output logic [ACC_W-1:0]  part2_result,
    output logic [CNT_W-1:0]  block_count,
    output logic              in_block,
    output logic              busy,
    output logic              done_,
    output logic              overflow,
    output logic              bad_digit
);

    localparam int KW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(ROWS - 1);
    localparam logic [ACC_W-1:0] ONE = ACC_W'(1);

    typedef enum logic [1:0] {
        ACCUM   = 2'd0,
        COMBINE = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [ACC_W-1:0] row_acc [ROWS];
    logic [ROWS-1:0]  row_seen;
    logic             blk_plus;
    logic [ACC_W-1:0] p2_acc;
    logic [ACC_W-1:0] p1_part;
    logic [KW-1:0]    k;
    logic             frame_q;

    logic             accept;
    logic             last_k;

    logic [ROWS-1:0]  d_ok;
    logic [ROWS-1:0]  d_bad;
    logic             op_c;
    logic [ACC_W-1:0] row_base [ROWS];
    logic [ACC_W+3:0] row_wide [ROWS];
    logic [ACC_W-1:0] row_nxt  [ROWS];
    logic [ROWS-1:0]  seen_nxt;
    logic             row_ovf;
    logic [ACC_W-1:0] col_chain [ROWS+1];
    logic [ACC_W+3:0] col_wide  [ROWS];
    logic             col_seen;
    logic             col_ovf;
    logic [ACC_W-1:0] p2_base;
    logic [ACC_W:0]   p2_sum;
    logic [2*ACC_W-1:0] p2_prod;
    logic [ACC_W-1:0] p2_nxt;
    logic             p2_ovf;

    logic [ACC_W-1:0] c_row;
    logic [ACC_W:0]   c_sum;
    logic [2*ACC_W-1:0] c_prod;
    logic [ACC_W-1:0] c_part;
    logic             c_ovf;
    logic [ACC_W:0]   r1_sum;
    logic [ACC_W:0]   r2_sum;

    function automatic logic [ACC_W+3:0] fold10(
        input logic [ACC_W-1:0] a,
        input logic [3:0]       d
    );
        logic [ACC_W+3:0] aw;
        aw = {4'b0000, a};
        fold10 = (aw << 3) + (aw << 1) + {{ACC_W{1'b0}}, d};
    endfunction

    function automatic logic [2*ACC_W-1:0] mul_w(
        input logic [ACC_W-1:0] a,
        input logic [ACC_W-1:0] b
    );
        mul_w = {{ACC_W{1'b0}}, a} * {{ACC_W{1'b0}}, b};
    endfunction

    assign accept = col_valid && ready && !load;
    assign last_k = (k == K_LAST);

    // Column path: row digit folds, column value, part2 block fold
    always_comb begin
        op_c = block_start ? block_plus : blk_plus;
        row_ovf = 1'b0;
        col_ovf = 1'b0;
        col_seen = 1'b0;
        col_chain[0] = '0;
        for (int r = 0; r < ROWS; r++) begin
            d_ok[r]  = !space[r] && (digit[4*r +: 4] <= 4'd9);
            d_bad[r] = !space[r] && (digit[4*r +: 4] > 4'd9);
            row_base[r] = block_start ? '0 : row_acc[r];
            row_wide[r] = fold10(row_base[r], digit[4*r +: 4]);
            col_wide[r] = fold10(col_chain[r], digit[4*r +: 4]);
            if (d_ok[r]) begin
                row_nxt[r] = row_wide[r][ACC_W-1:0];
                seen_nxt[r] = 1'b1;
                row_ovf = row_ovf | (|row_wide[r][ACC_W+3:ACC_W]);
                col_chain[r+1] = col_wide[r][ACC_W-1:0];
                col_ovf = col_ovf | (|col_wide[r][ACC_W+3:ACC_W]);
                col_seen = 1'b1;
            end else begin
                row_nxt[r] = row_base[r];
                seen_nxt[r] = block_start ? 1'b0 : row_seen[r];
                col_chain[r+1] = col_chain[r];
            end
        end
        if (block_start)
            p2_base = block_plus ? '0 : ONE;
        else
            p2_base = p2_acc;
        p2_sum  = {1'b0, p2_base} + {1'b0, col_chain[ROWS]};
        p2_prod = mul_w(p2_base, col_chain[ROWS]);
        p2_nxt  = p2_base;
        p2_ovf  = 1'b0;
        if (col_seen) begin
            if (op_c) begin
                p2_nxt = p2_sum[ACC_W-1:0];
                p2_ovf = p2_sum[ACC_W];
            end else begin
                p2_nxt = p2_prod[ACC_W-1:0];
                p2_ovf = |p2_prod[2*ACC_W-1:ACC_W];
            end
        end
    end

    // Combine path: fold row k into part1 partial, final result adds
    always_comb begin
        c_row  = row_acc[k];
        c_sum  = {1'b0, p1_part} + {1'b0, c_row};
        c_prod = mul_w(p1_part, c_row);
        c_part = p1_part;
        c_ovf  = 1'b0;
        if (row_seen[k]) begin
            if (blk_plus) begin
                c_part = c_sum[ACC_W-1:0];
                c_ovf  = c_sum[ACC_W];
            end else begin
                c_part = c_prod[ACC_W-1:0];
                c_ovf  = |c_prod[2*ACC_W-1:ACC_W];
            end
        end
        r1_sum = {1'b0, part1_result} + {1'b0, c_part};
        r2_sum = {1'b0, part2_result} + {1'b0, p2_acc};
    end

    // State register
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n)
            state <= ACCUM;
        else
            state <= state_nxt;
    end

    // Next-state logic; load always returns to ACCUM
    always_comb begin
        state_nxt = state;
        unique case (state)
            ACCUM:   if (accept && col_last) state_nxt = COMBINE;
            COMBINE: if (last_k) state_nxt = frame_q ? DONE : ACCUM;
            DONE:    state_nxt = DONE;
            default: state_nxt = ACCUM;
        endcase
        if (load)
            state_nxt = ACCUM;
    end

    // State-decoded handshake and status outputs
    always_comb begin
        ready = (state == ACCUM);
        busy  = (state == COMBINE);
        done_ = (state == DONE);
    end

    // Datapath registers, results and sticky flags
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            for (int r = 0; r < ROWS; r++) row_acc[r] <= '0;
            row_seen     <= '0;
            blk_plus     <= 1'b0;
            p2_acc       <= '0;
            p1_part      <= '0;
            k            <= '0;
            frame_q      <= 1'b0;
            part1_result <= '0;
            part2_result <= '0;
            block_count  <= '0;
            in_block     <= 1'b0;
            overflow     <= 1'b0;
            bad_digit    <= 1'b0;
        end else if (load) begin
            for (int r = 0; r < ROWS; r++) row_acc[r] <= '0;
            row_seen     <= '0;
            blk_plus     <= 1'b0;
            p2_acc       <= '0;
            p1_part      <= '0;
            k            <= '0;
            frame_q      <= 1'b0;
            part1_result <= '0;
            part2_result <= '0;
            block_count  <= '0;
            in_block     <= 1'b0;
            overflow     <= 1'b0;
            bad_digit    <= 1'b0;
        end else begin
            unique case (state)
                ACCUM: begin
                    if (accept) begin
                        for (int r = 0; r < ROWS; r++)
                            row_acc[r] <= row_nxt[r];
                        row_seen  <= seen_nxt;
                        blk_plus  <= op_c;
                        p2_acc    <= p2_nxt;
                        bad_digit <= bad_digit | (|d_bad);
                        overflow  <= overflow | row_ovf | col_ovf | p2_ovf;
                        if (block_start)
                            in_block <= 1'b1;
                        if (col_last) begin
                            frame_q <= frame_last;
                            k       <= '0;
                            p1_part <= op_c ? '0 : ONE;
                        end
                    end
                end
                COMBINE: begin
                    p1_part  <= c_part;
                    k        <= k + 1'b1;
                    overflow <= overflow | c_ovf |
                                (last_k & (r1_sum[ACC_W] | r2_sum[ACC_W]));
                    if (last_k) begin
                        part1_result <= r1_sum[ACC_W-1:0];
                        part2_result <= r2_sum[ACC_W-1:0];
                        block_count  <= block_count + 1'b1;
                        in_block     <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
